alu_result_checker: RTL and testbench

Receiving end of the ALU datapath. It accepts the operand/select triple together with the result the ALU produced, recomputes the expected result with its own model, and compares the two. It keeps saturating pass and fail counters, a sticky error flag, and a snapshot of the first failing vector. It sits on the bench and board-test side of the ALU: the stimulus source drives X/Y/S into the ALU and this block in parallel.

---
 rtl/alu_result_checker.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_result_checker.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_checker.sv
// alu_result_checker
//   Receiving end of the ALU datapath. Each accepted vector (x, y, s, o) is
//   run through a private model of the ALU and the model's answer is compared
//   with the ALU's answer o. Keeps saturating pass/fail counters, a sticky
//   error flag and a snapshot of the first failing vector.
//
//   Handshake: a vector transfers on a rising clk edge where in_valid and
//   in_ready are both high. in_valid may be asserted at any time and does not
//   need to wait for in_ready. in_ready is a registered decode of the RUN state,
//   so it drops on the edge after a failing compare. res_valid is a one-cycle
//   pulse with no back-pressure, and res_pass is meaningful only while res_valid
//   is high.
//
//   Pipeline: edge T captures the vector, edge T+1 registers the expected value,
//   and edge T+2 registers the compare along with the counters and snapshot.
//   The halted output exposes the FSM state.

module alu_result_checker #(
   parameter int N            = 3,
   parameter int CNT_W        = 8,
   parameter int HALT_ON_FAIL = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N:0]       x,
   input  logic [N:0]       y,
   input  logic [2:0]       s,
   input  logic [N+2:0]     o,
   output logic [CNT_W-1:0] pass_count,
   output logic [CNT_W-1:0] fail_count,
   output logic             err_flag,
   output logic             halted,
   output logic             res_valid,
   output logic             res_pass,
   output logic [N:0]       ff_x,
   output logic [N:0]       ff_y,
   output logic [2:0]       ff_s,
   output logic [N+2:0]     ff_o,
   output logic [N+2:0]     ff_exp
);

   localparam int XW = N + 1;   // operand width
   localparam int RW = N + 3;   // result width

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_HALT = 1'b1;

   // Signed divide by two, truncating toward zero: negative odd values are
   // nudged up by one so the arithmetic shift rounds toward zero, not down.
   function automatic logic [RW-1:0] half_tz(input logic [RW-1:0] v);
      logic [RW-1:0] adj;
      adj = v + {{(RW-1){1'b0}}, v[RW-1]};
      return {adj[RW-1], adj[RW-1:1]};
   endfunction

   // Counter increment that sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
   endfunction

   logic [0:0]    state;
   logic [0:0]    state_nxt;
   logic          accept;

   // Stage 1: captured vector
   logic          s1_v;
   logic [XW-1:0] s1_x;
   logic [XW-1:0] s1_y;
   logic [2:0]    s1_s;
   logic [RW-1:0] s1_o;

   // Stage 2: vector plus expected result
   logic          s2_v;
   logic [XW-1:0] s2_x;
   logic [XW-1:0] s2_y;
   logic [2:0]    s2_s;
   logic [RW-1:0] s2_o;
   logic [RW-1:0] s2_exp;
   logic          s2_match;

   // Model working values
   logic [RW-1:0] xe;
   logic [RW-1:0] ye;
   logic [RW-1:0] sum;
   logic [XW-1:0] xr;
   logic [RW-1:0] exp_nxt;

   assign accept   = in_valid & in_ready;
   assign halted   = (state == ST_HALT);
   assign s2_match = (s2_o == s2_exp);

   // Stage 1: take a vector whenever the handshake completes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_v <= 1'b0;
         s1_x <= '0;
         s1_y <= '0;
         s1_s <= '0;
         s1_o <= '0;
      end else begin
         s1_v <= accept;
         if (accept) begin
            s1_x <= x;
            s1_y <= y;
            s1_s <= s;
            s1_o <= o;
         end
      end
   end

   // Reference ALU: operands sign-extended and evaluated at result width
   always_comb begin
      xe      = {{(RW-XW){s1_x[XW-1]}}, s1_x};
      ye      = {{(RW-XW){s1_y[XW-1]}}, s1_y};
      sum     = xe + ye;
      xr      = s1_x ^ s1_y;
      exp_nxt = '0;
      case (s1_s)
         3'b000:  exp_nxt = half_tz(sum);
         3'b001:  exp_nxt = {sum[RW-2:0], 1'b0};
         3'b010:  exp_nxt = half_tz(xe) + ye;
         3'b011:  exp_nxt = xe - half_tz(ye);
         3'b100:  exp_nxt = {{(RW-1){1'b0}}, ((s1_x & s1_y) == '0)};
         3'b101:  exp_nxt = {{(RW-1){1'b0}}, (s1_x == '0)};
         3'b110:  exp_nxt = {{(RW-1){1'b0}}, ((s1_x | s1_y) == '0)};
         default: exp_nxt = {{(RW-XW){xr[XW-1]}}, xr};
      endcase
   end

   // Stage 2: register the expected result alongside the vector
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s2_v   <= 1'b0;
         s2_x   <= '0;
         s2_y   <= '0;
         s2_s   <= '0;
         s2_o   <= '0;
         s2_exp <= '0;
      end else begin
         s2_v <= s1_v;
         if (s1_v) begin
            s2_x   <= s1_x;
            s2_y   <= s1_y;
            s2_s   <= s1_s;
            s2_o   <= s1_o;
            s2_exp <= exp_nxt;
         end
      end
   end

   // Next state: clear always returns to RUN, a failing compare may halt
   always_comb begin
      state_nxt = state;
      if (clear)
         state_nxt = ST_RUN;
      else if (s2_v && !s2_match && (HALT_ON_FAIL != 0))
         state_nxt = ST_HALT;
   end

   // State register and its registered ready decode
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_RUN;
         in_ready <= 1'b1;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt == ST_RUN);
      end
   end

   // Compare result pulse; reported even when clear drops it from the counts
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_valid <= 1'b0;
         res_pass  <= 1'b0;
      end else begin
         res_valid <= s2_v;
         if (s2_v)
            res_pass <= s2_match;
      end
   end

   // Statistics and first-fail snapshot; clear has priority over a compare
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pass_count <= '0;
         fail_count <= '0;
         err_flag   <= 1'b0;
         ff_x       <= '0;
         ff_y       <= '0;
         ff_s       <= '0;
         ff_o       <= '0;
         ff_exp     <= '0;
      end else if (clear) begin
         pass_count <= '0;
         fail_count <= '0;
         err_flag   <= 1'b0;
         ff_x       <= '0;
         ff_y       <= '0;
         ff_s       <= '0;
         ff_o       <= '0;
         ff_exp     <= '0;
      end else if (s2_v) begin
         if (s2_match) begin
            pass_count <= sat_inc(pass_count);
         end else begin
            fail_count <= sat_inc(fail_count);
            err_flag   <= 1'b1;
            if (!err_flag) begin
               ff_x   <= s2_x;
               ff_y   <= s2_y;
               ff_s   <= s2_s;
               ff_o   <= s2_o;
               ff_exp <= s2_exp;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: randomized and directed vectors, expected
// results from an integer-arithmetic ALU model, scoreboard queue drained by
// an independent monitor.

module tb_alu_result_checker;

   localparam int N     = 3;
   localparam int CNT_W = 8;
   localparam int RW    = N + 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- main DUT (CNT_W=8, halting) ----------------
   logic             clear = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [N:0]       x = '0;
   logic [N:0]       y = '0;
   logic [2:0]       s = '0;
   logic [RW-1:0]    o = '0;
   logic [CNT_W-1:0] pass_count;
   logic [CNT_W-1:0] fail_count;
   logic             err_flag;
   logic             halted;
   logic             res_valid;
   logic             res_pass;
   logic [N:0]       ff_x;
   logic [N:0]       ff_y;
   logic [2:0]       ff_s;
   logic [RW-1:0]    ff_o;
   logic [RW-1:0]    ff_exp;

   alu_result_checker #(.N(N), .CNT_W(CNT_W), .HALT_ON_FAIL(1)) u_dut (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
      .in_ready(in_ready), .x(x), .y(y), .s(s), .o(o),
      .pass_count(pass_count), .fail_count(fail_count), .err_flag(err_flag),
      .halted(halted), .res_valid(res_valid), .res_pass(res_pass),
      .ff_x(ff_x), .ff_y(ff_y), .ff_s(ff_s), .ff_o(ff_o), .ff_exp(ff_exp)
   );

   // ---------------- second DUT (CNT_W=2, non-halting) ----------------
   logic          clear2 = 1'b0;
   logic          in_valid2 = 1'b0;
   logic          in_ready2;
   logic [N:0]    x2 = '0;
   logic [N:0]    y2 = '0;
   logic [2:0]    s2 = '0;
   logic [RW-1:0] o2 = '0;
   logic [1:0]    pass_count2;
   logic [1:0]    fail_count2;
   logic          err_flag2;
   logic          halted2;
   logic          res_valid2;
   logic          res_pass2;
   logic [N:0]    ff_x2;
   logic [N:0]    ff_y2;
   logic [2:0]    ff_s2;
   logic [RW-1:0] ff_o2;
   logic [RW-1:0] ff_exp2;

   alu_result_checker #(.N(N), .CNT_W(2), .HALT_ON_FAIL(0)) u_dut2 (
      .clk(clk), .reset(reset), .clear(clear2), .in_valid(in_valid2),
      .in_ready(in_ready2), .x(x2), .y(y2), .s(s2), .o(o2),
      .pass_count(pass_count2), .fail_count(fail_count2), .err_flag(err_flag2),
      .halted(halted2), .res_valid(res_valid2), .res_pass(res_pass2),
      .ff_x(ff_x2), .ff_y(ff_y2), .ff_s(ff_s2), .ff_o(ff_o2), .ff_exp(ff_exp2)
   );

   // ---------------- reference model ----------------
   function automatic logic [RW-1:0] model(input logic [N:0] xv, input logic [N:0] yv,
                                            input logic [2:0] sv);
      int xi;
      int yi;
      int r;
      xi = $signed(xv);
      yi = $signed(yv);
      case (sv)
         3'd0:    r = (xi + yi) / 2;
         3'd1:    r = (xi + yi) * 2;
         3'd2:    r = xi / 2 + yi;
         3'd3:    r = xi - yi / 2;
         3'd4:    r = ((xv & yv) == 0) ? 1 : 0;
         3'd5:    r = (xv == 0) ? 1 : 0;
         3'd6:    r = ((xv | yv) == 0) ? 1 : 0;
         default: r = $signed(xv ^ yv);
      endcase
      return r[RW-1:0];
   endfunction

   int            m_pass = 0;
   int            m_fail = 0;
   bit            m_err = 1'b0;
   bit            m_halt = 1'b0;
   logic [N:0]    m_fx = '0;
   logic [N:0]    m_fy = '0;
   logic [2:0]    m_fs = '0;
   logic [RW-1:0] m_fo = '0;
   logic [RW-1:0] m_fe = '0;

   task automatic model_zero();
      m_pass = 0; m_fail = 0; m_err = 1'b0; m_halt = 1'b0;
      m_fx = '0; m_fy = '0; m_fs = '0; m_fo = '0; m_fe = '0;
   endtask

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [N:0]    x;
      logic [N:0]    y;
      logic [2:0]    s;
      logic [RW-1:0] o;
      logic [RW-1:0] e;
      logic [31:0]   cyc;
   } vec_t;

   vec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- monitor ----------------
   vec_t mon_e;
   bit   mon_p;

   always @(negedge clk) begin
      if (!reset) begin
         if (res_valid) begin
            chk("result_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               mon_p = (mon_e.o == mon_e.e);
               chk("res_pass", res_pass, mon_p);
               chk("latency", cyc, mon_e.cyc + 2);
               if (!clear) begin
                  if (mon_p) begin
                     m_pass = (m_pass < 255) ? m_pass + 1 : 255;
                  end else begin
                     m_fail = (m_fail < 255) ? m_fail + 1 : 255;
                     if (!m_err) begin
                        m_fx = mon_e.x; m_fy = mon_e.y; m_fs = mon_e.s;
                        m_fo = mon_e.o; m_fe = mon_e.e;
                     end
                     m_err  = 1'b1;
                     m_halt = 1'b1;
                  end
               end
            end
         end
         if (clear) model_zero();
         if (res_valid || clear) begin
            chk("pass_count", pass_count, m_pass);
            chk("fail_count", fail_count, m_fail);
            chk("err_flag", err_flag, m_err);
            chk("halted", halted, m_halt);
            chk("ff_x", ff_x, m_fx);
            chk("ff_y", ff_y, m_fy);
            chk("ff_s", ff_s, m_fs);
            chk("ff_o", ff_o, m_fo);
            chk("ff_exp", ff_exp, m_fe);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [N:0] xv, input logic [N:0] yv,
                       input logic [2:0] sv, input logic [RW-1:0] ov);
      vec_t e;
      @(negedge clk); #1;
      chk("in_ready", in_ready, !m_halt);
      x = xv; y = yv; s = sv; o = ov;
      in_valid = 1'b1;
      if (!m_halt) begin
         e.x = xv; e.y = yv; e.s = sv; e.o = ov;
         e.e = model(xv, yv, sv);
         e.cyc = cyc + 1;
         exp_q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      idle(1);
      while (exp_q.size() != 0 && k < 20) begin
         idle(1);
         k++;
      end
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic do_clear();
      @(negedge clk); #1;
      in_valid = 1'b0;
      clear = 1'b1;
      @(negedge clk); #1;
      clear = 1'b0;
   endtask

   task automatic send_rand(input int good_pct);
      logic [N:0]    rx;
      logic [N:0]    ry;
      logic [2:0]    rs;
      logic [RW-1:0] ro;
      rx = 4'($urandom_range(0, 15));
      ry = 4'($urandom_range(0, 15));
      rs = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < good_pct) ro = model(rx, ry, rs);
      else ro = 6'($urandom_range(0, 63));
      send(rx, ry, rs, ro);
   endtask

   task automatic send2(input logic [N:0] xv, input logic [N:0] yv,
                        input logic [2:0] sv, input logic [RW-1:0] ov);
      @(negedge clk); #1;
      x2 = xv; y2 = yv; s2 = sv; o2 = ov;
      in_valid2 = 1'b1;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      logic [N:0] px;
      logic [N:0] py;
      logic [2:0] ps;

      repeat (3) @(negedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_pass_count", pass_count, 0);
      chk("rst_fail_count", fail_count, 0);
      chk("rst_err_flag", err_flag, 0);
      chk("rst_halted", halted, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_pass", res_pass, 0);
      chk("rst_ff_exp", ff_exp, 0);

      // Basic average
      send(4'd3, 4'd2, 3'b000, 6'd2);
      drain();

      // Negative average passes, then the doubled sum is wrong
      send(4'(-3), 4'(-2), 3'b000, 6'b111110);
      send(4'(-3), 4'(-2), 3'b001, 6'b101010);
      drain();
      chk("ff_exp_neg10", ff_exp, 6'b110110);
      do_clear();

      // Back-to-back passes
      send(4'd7, 4'd7, 3'b001, 6'd28);
      send(4'd4, 4'd3, 3'b100, 6'd1);
      send(4'd0, 4'd5, 3'b101, 6'd1);
      drain();
      chk("b2b_pass_count", pass_count, 3);

      // XOR mismatch halts the checker; a further vector is refused
      send(4'd5, 4'd3, 3'b111, 6'd7);
      drain();
      chk("halt_in_ready", in_ready, 0);
      send(4'd2, 4'd2, 3'b000, 6'd2);
      idle(4);
      do_clear();
      chk("clr_in_ready", in_ready, 1);

      // Clear on the same edge as a completing failure: clear wins
      send(4'd1, 4'd1, 3'b111, 6'd1);
      idle(1);
      @(negedge clk); #1 clear = 1'b1;
      @(negedge clk); #1 clear = 1'b0;
      drain();

      // Random mix of passes and failures
      for (int i = 0; i < 200; i++) begin
         if (m_halt) begin
            drain();
            do_clear();
         end
         send_rand(85);
      end
      drain();
      do_clear();

      // Saturation of the 8-bit pass counter
      for (int i = 0; i < 260; i++) send_rand(100);
      drain();
      chk("sat_pass_count", pass_count, 255);

      // Reset with two vectors in flight
      send(4'd1, 4'd2, 3'b010, model(4'd1, 4'd2, 3'b010));
      send(4'd6, 4'd1, 3'b011, model(4'd6, 4'd1, 3'b011));
      @(negedge clk); #1;
      in_valid = 1'b0;
      reset = 1'b1;
      exp_q.delete();
      model_zero();
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      idle(5);
      chk("rst_mid_pass_count", pass_count, 0);
      chk("rst_mid_fail_count", fail_count, 0);

      // Non-halting checker with 2-bit counters
      for (int i = 0; i < 5; i++) begin
         px = 4'($urandom_range(0, 15));
         py = 4'($urandom_range(0, 15));
         ps = 3'($urandom_range(0, 7));
         send2(px, py, ps, model(px, py, ps));
      end
      send2(4'd1, 4'd1, 3'b111, 6'd1);
      send2(4'd2, 4'd5, 3'b111, 6'd0);
      @(negedge clk); #1 in_valid2 = 1'b0;
      repeat (4) @(negedge clk);
      chk("d2_pass_sat", pass_count2, 3);
      chk("d2_fail_count", fail_count2, 2);
      chk("d2_ff_x", ff_x2, 1);
      chk("d2_ff_o", ff_o2, 1);
      chk("d2_ff_exp", ff_exp2, model(4'd1, 4'd1, 3'b111));
      chk("d2_err_flag", err_flag2, 1);
      chk("d2_halted", halted2, 0);
      chk("d2_in_ready", in_ready2, 1);

      chk("final_queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
